// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Shared types and constants for the 3x3 convolution front-end.
//   state_t     : sequencer FSM states
//   rgb565_t    : packed RGB565 pixel, R[15:11] G[10:5] B[4:0]
//   tap_t       : signed kernel tap
//   bias_t      : signed bias
//   CFG_BIAS_G / CFG_BIAS_RB : configuration addresses of the two biases
// -----------------------------------------------------------------------------
package conv_pkg;

  localparam int PIX_W    = 16;
  localparam int TAP_W    = 6;
  localparam int BIAS_W   = 10;
  localparam int NUM_TAPS = 9;

  localparam logic [3:0] CFG_LAST_TAP = 4'd8;
  localparam logic [3:0] CFG_BIAS_G   = 4'd9;
  localparam logic [3:0] CFG_BIAS_RB  = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_STREAM,
    ST_FLUSH
  } state_t;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  typedef logic signed [TAP_W-1:0]  tap_t;
  typedef logic signed [BIAS_W-1:0] bias_t;

  // Addresses 0..8 select a kernel tap.
  function automatic logic is_tap_addr(input logic [3:0] addr);
    return addr <= CFG_LAST_TAP;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// -----------------------------------------------------------------------------
// conv_line_buffer
// One image line of RGB565 pixels: simple dual-port RAM, one write port and
// one synchronous read port. A read and a write to the same address in the
// same cycle return the old contents.
//   clk      : clock
//   wr_en    : write strobe
//   wr_addr  : write address (column)
//   wr_data  : write pixel
//   rd_en    : read strobe; rd_data updates only when set
//   rd_addr  : read address (column)
//   rd_data  : registered read pixel
// -----------------------------------------------------------------------------
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int DEPTH  = 320,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  rgb565_t           wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output rgb565_t           rd_data
);

  rgb565_t mem [DEPTH];

  // NOTE: the RAM and its read register carry no reset so the array maps onto
  // block RAM; the sequencer never uses a read without a matching write first.
  // Both updates are non-blocking, so a same-address read sees the old word.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/conv_window_sequencer.sv
// -----------------------------------------------------------------------------
// conv_window_sequencer
// Turns a raster-order RGB565 frame into one 3x3 window per interior pixel
// (valid-only convolution) for the convolution engine, and holds the
// double-buffered kernel/bias configuration.
//   clk, reset        : clock, synchronous active-high reset
//   start             : frame start pulse, honoured in IDLE only
//   in_valid/in_ready : pixel stream handshake, in_pixel carries the pixel
//   cfg_wr/addr/data  : shadow config write (0-8 taps, 9 bias_g, 10 bias_rb)
//   win_valid         : one-cycle strobe per window
//   win_pixels[0:8]   : window, index 3*dy+dx (0 = top-left)
//   kernel[0:8]       : active taps
//   scale_bias_g/rb   : active biases
//   busy, done        : frame in progress, end-of-frame pulse
// Pipeline: transfer at cycle N -> line-buffer read at N+1 -> window at N+2.
// -----------------------------------------------------------------------------
module conv_window_sequencer
  import conv_pkg::*;
#(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [15:0]        in_pixel,
  input  logic               cfg_wr,
  input  logic [3:0]         cfg_addr,
  input  logic [9:0]         cfg_data,
  output logic               win_valid,
  output logic [15:0]        win_pixels [0:8],
  output logic signed [5:0]  kernel [0:8],
  output logic signed [9:0]  scale_bias_g,
  output logic signed [9:0]  scale_bias_rb,
  output logic               busy,
  output logic               done
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);

  state_t           state;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             flush_cnt;

  logic xfer;
  logic start_ok;

  assign xfer     = in_valid && in_ready;
  assign start_ok = start && (state == ST_IDLE);

  // ---------------------------------------------------------------------------
  // Control FSM: position counters and registered handshake/status outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      col       <= '0;
      row       <= '0;
      flush_cnt <= 1'b0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_FILL;
            col      <= '0;
            row      <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        ST_FILL, ST_STREAM: begin
          if (xfer) begin
            if (col == LAST_COL) begin
              col <= '0;
              if (row == LAST_ROW) begin
                row       <= '0;
                state     <= ST_FLUSH;
                in_ready  <= 1'b0;
                flush_cnt <= 1'b0;
              end else begin
                row <= row + 1'b1;
                // Two full lines buffered: windows start with the next line.
                if (row == ROW_W'(1)) begin
                  state <= ST_STREAM;
                end
              end
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        ST_FLUSH: begin
          // Cycle N+1: last window sits in stage 1, raise done with it.
          // Cycle N+2: done is visible, drop busy and return to IDLE.
          if (!flush_cnt) begin
            flush_cnt <= 1'b1;
            done      <= 1'b1;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: capture the accepted pixel alongside the line-buffer read.
  // ---------------------------------------------------------------------------
  logic             s1_valid;
  logic             s1_emit;
  rgb565_t          s1_pixel;
  logic [COL_W-1:0] s1_col;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_emit  <= 1'b0;
      s1_pixel <= '0;
      s1_col   <= '0;
    end else begin
      s1_valid <= xfer;
      s1_emit  <= xfer && (state == ST_STREAM) && (col >= COL_W'(2));
      if (xfer) begin
        s1_pixel <= in_pixel;
        s1_col   <= col;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Line buffers: lb1 holds line r-1, lb0 holds line r-2 (both at col).
  // lb1's old word only exists after its synchronous read, so the lb1 -> lb0
  // move is written one cycle later at the captured column. The concurrent
  // read is always at a different column, so ordering is preserved.
  // ---------------------------------------------------------------------------
  rgb565_t lb0_q;
  rgb565_t lb1_q;

  conv_line_buffer #(
    .DEPTH  (IMG_WIDTH),
    .ADDR_W (COL_W)
  ) u_lb0 (
    .clk     (clk),
    .wr_en   (s1_valid),
    .wr_addr (s1_col),
    .wr_data (lb1_q),
    .rd_en   (xfer),
    .rd_addr (col),
    .rd_data (lb0_q)
  );

  conv_line_buffer #(
    .DEPTH  (IMG_WIDTH),
    .ADDR_W (COL_W)
  ) u_lb1 (
    .clk     (clk),
    .wr_en   (xfer),
    .wr_addr (col),
    .wr_data (in_pixel),
    .rd_en   (xfer),
    .rd_addr (col),
    .rd_data (lb1_q)
  );

  // ---------------------------------------------------------------------------
  // Stage 2: 3x3 window register, shifted one column left per transfer.
  // The new right-hand column is {line r-2, line r-1, current pixel}.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      win_valid <= 1'b0;
      for (int i = 0; i < NUM_TAPS; i++) begin
        win_pixels[i] <= '0;
      end
    end else begin
      win_valid <= s1_emit;
      if (s1_valid) begin
        for (int dy = 0; dy < 3; dy++) begin
          win_pixels[3*dy]     <= win_pixels[3*dy + 1];
          win_pixels[3*dy + 1] <= win_pixels[3*dy + 2];
        end
        win_pixels[2] <= lb0_q;
        win_pixels[5] <= lb1_q;
        win_pixels[8] <= s1_pixel;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Configuration: shadow registers written any time, copied to the active
  // set only on an accepted start. A write in the start cycle lands in the
  // shadow after the copy has sampled the old value.
  // ---------------------------------------------------------------------------
  tap_t  shadow_k [0:8];
  bias_t shadow_bias_g;
  bias_t shadow_bias_rb;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        shadow_k[i] <= '0;
        kernel[i]   <= '0;
      end
      shadow_bias_g  <= '0;
      shadow_bias_rb <= '0;
      scale_bias_g   <= '0;
      scale_bias_rb  <= '0;
    end else begin
      if (cfg_wr) begin
        if (is_tap_addr(cfg_addr)) begin
          shadow_k[cfg_addr] <= cfg_data[TAP_W-1:0];
        end else if (cfg_addr == CFG_BIAS_G) begin
          shadow_bias_g <= cfg_data;
        end else if (cfg_addr == CFG_BIAS_RB) begin
          shadow_bias_rb <= cfg_data;
        end
      end
      if (start_ok) begin
        kernel        <= shadow_k;
        scale_bias_g  <= shadow_bias_g;
        scale_bias_rb <= shadow_bias_rb;
      end
    end
  end

endmodule
